// File: rtl/ycr1_pipe_mprf_wb_arb.sv
// rtl/ycr1_pipe_mprf_wb_arb.sv - write-back arbiter and load scoreboard for the MPRF write port
module ycr1_pipe_mprf_wb_arb #(
    parameter int AWIDTH   = 5,
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_wb_vld_i,
    input  logic [AWIDTH-1:0] alu_wb_rd_i,
    input  logic [XLEN-1:0]   alu_wb_data_i,
    input  logic              lsu_issue_vld_i,
    input  logic [AWIDTH-1:0] lsu_issue_rd_i,
    input  logic              lsu_wb_vld_i,
    input  logic              lsu_wb_err_i,
    input  logic [AWIDTH-1:0] lsu_wb_rd_i,
    input  logic [XLEN-1:0]   lsu_wb_data_i,
    output logic              lsu_wb_rdy_o,
    input  logic [AWIDTH-1:0] exu_rs1_addr_i,
    input  logic [AWIDTH-1:0] exu_rs2_addr_i,
    input  logic              exu_rd_vld_i,
    input  logic [AWIDTH-1:0] exu_rd_addr_i,
    output logic              hzd_stall_o,
    output logic              exu2mprf_w_req_o,
    output logic [AWIDTH-1:0] exu2mprf_rd_addr_o,
    output logic [XLEN-1:0]   exu2mprf_rd_data_o
);

    localparam int PW   = $clog2(LQ_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << AWIDTH;

    logic [NREG-1:0]   sb;
    logic [NREG-1:0]   sb_set;
    logic [NREG-1:0]   sb_clr;
    logic [AWIDTH-1:0] q_rd   [LQ_DEPTH];
    logic [XLEN-1:0]   q_data [LQ_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic q_nempty;
    logic ret_acc;
    logic pop;
    logic bypass;
    logic push;
    logic err_clr;

    // Readiness comes from the registered count only, so a full queue refuses
    // a return even in a cycle where the head is being popped.
    assign q_nempty     = (count != '0);
    assign lsu_wb_rdy_o = (count < CW'(LQ_DEPTH));
    assign ret_acc      = lsu_wb_vld_i & lsu_wb_rdy_o;
    assign pop          = ~alu_wb_vld_i & q_nempty;
    assign bypass       = ~alu_wb_vld_i & ~q_nempty & lsu_wb_vld_i & ~lsu_wb_err_i;
    assign push         = ret_acc & ~lsu_wb_err_i & ~bypass;
    assign err_clr      = ret_acc & lsu_wb_err_i;

    // Write-port mux: ALU first, then queued loads, then a direct load bypass; x0 never writes
    always_comb begin
        exu2mprf_w_req_o   = 1'b0;
        exu2mprf_rd_addr_o = '0;
        exu2mprf_rd_data_o = '0;
        if (alu_wb_vld_i) begin
            exu2mprf_w_req_o   = |alu_wb_rd_i;
            exu2mprf_rd_addr_o = alu_wb_rd_i;
            exu2mprf_rd_data_o = alu_wb_data_i;
        end else if (q_nempty) begin
            exu2mprf_w_req_o   = |q_rd[rd_ptr];
            exu2mprf_rd_addr_o = q_rd[rd_ptr];
            exu2mprf_rd_data_o = q_data[rd_ptr];
        end else if (bypass) begin
            exu2mprf_w_req_o   = |lsu_wb_rd_i;
            exu2mprf_rd_addr_o = lsu_wb_rd_i;
            exu2mprf_rd_data_o = lsu_wb_data_i;
        end
    end

    // Scoreboard set/clear vectors; a pop and an error return may clear two bits at once
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (lsu_issue_vld_i && (|lsu_issue_rd_i)) sb_set[lsu_issue_rd_i] = 1'b1;
        if (pop)                                  sb_clr[q_rd[rd_ptr]]   = 1'b1;
        if (bypass || err_clr)                    sb_clr[lsu_wb_rd_i]    = 1'b1;
    end

    // Scoreboard register; set is applied after clear so a same-cycle reissue stays busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb <= (sb & ~sb_clr) | sb_set;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are meaningless while count says empty, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lsu_wb_rd_i;
            q_data[wr_ptr] <= lsu_wb_data_i;
        end
    end

    assign hzd_stall_o = ((|exu_rs1_addr_i) & sb[exu_rs1_addr_i])
                       | ((|exu_rs2_addr_i) & sb[exu_rs2_addr_i])
                       | (exu_rd_vld_i & (|exu_rd_addr_i) & sb[exu_rd_addr_i]);

    // The stall keeps the EXU from creating a WAW on a register with a load in flight
    a_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(lsu_issue_vld_i && (|lsu_issue_rd_i) && sb[lsu_issue_rd_i]));
    a_alu_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(alu_wb_vld_i && (|alu_wb_rd_i) && sb[alu_wb_rd_i]));

endmodule
